uart_rx: RTL

Serial UART receiver for the rv_soc peripheral set. It is the receive counterpart of the SoC's UART transmit path. It deserialises an 8N1 asynchronous line into bytes using a clock-cycle bit timer. Received bytes are buffered in a small first-word-fall-through FIFO and presented to the bus/GPIO side with a valid/ready handshake. Framing and overrun errors are reported as sticky flags.

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchroniser, mid-bit sampling FSM,
// first-word-fall-through receive FIFO and sticky framing/overrun flags.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level on rx_s
// START     | half a bit period into the start bit, confirm it is still low
// DATA      | sample 8 data bits LSB first, one per bit period
// STOP      | sample stop bit; high pushes the byte, low flags a framing error
// WAIT_IDLE | after a framing error, hold off until the line returns high
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  input  logic       i_clear_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_meta;
  logic          rx_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic stop_tick;
  logic push;
  logic frame_evt;
  logic pop;
  logic full;
  logic do_push;
  logic ovf_evt;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  assign stop_tick = (state == STOP) && (cnt == FULL_M1);
  assign push      = stop_tick && rx_s;
  assign frame_evt = stop_tick && !rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            cnt           <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : WAIT_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_valid = (count != '0);
  assign o_data  = mem[rd_ptr];
  assign pop     = o_valid && i_ready;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  // A full FIFO still accepts the new byte when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign ovf_evt = push && full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      if (i_clear_err) begin
        o_frame_err <= 1'b0;
        o_overrun   <= 1'b0;
      end
      if (frame_evt) o_frame_err <= 1'b1;
      if (ovf_evt)   o_overrun   <= 1'b1;
    end
  end

endmodule
